// File: rtl/sram_block_mover.sv
// Block copy / block fill engine that masters a single-port word SRAM.
// Copy alternates READ and WRITE per word; fill writes one word per cycle.
module sram_block_mover #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [ADDR_WIDTH:0]   i_len,
  input  logic [31:0]           i_fill,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [31:0]           o_mem_data,
  input  logic [31:0]           i_mem_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d, count_q, count_d;
  logic                  mode_q, mode_d, busy_q, busy_d, done_q, done_d, wr_q, wr_d;
  logic [31:0]           fill_q, fill_d, data_q, data_d, wdata_q, wdata_d;

  // Next-state and operand register updates.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    count_d = count_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          src_d   = i_src;
          dst_d   = i_dst;
          len_d   = i_len;
          mode_d  = i_mode;
          fill_d  = i_fill;
          count_d = LEN_ZERO;
          if (i_len == LEN_ZERO) begin
            state_d = ST_DONE;
          end else if (i_mode) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        data_d  = i_mem_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        dst_d   = dst_q + ADDR_ONE;
        count_d = count_q + LEN_ONE;
        len_d   = len_q - LEN_ONE;
        if (!mode_q) begin
          src_d = src_q + ADDR_ONE;
        end else begin
          src_d = src_q;
        end
        if (len_q == LEN_ONE) begin
          state_d = ST_DONE;
        end else if (mode_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered: decode them from the state being entered.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wr_d    = 1'b0;
    addr_d  = ADDR_ZERO;
    wdata_d = 32'h0000_0000;
    case (state_d)
      ST_READ: begin
        busy_d = 1'b1;
        addr_d = src_d;
      end
      ST_WRITE: begin
        busy_d  = 1'b1;
        wr_d    = 1'b1;
        addr_d  = dst_d;
        wdata_d = mode_d ? fill_d : data_d;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, operand and output registers; reset clears everything at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      src_q   <= ADDR_ZERO;
      dst_q   <= ADDR_ZERO;
      len_q   <= LEN_ZERO;
      count_q <= LEN_ZERO;
      mode_q  <= 1'b0;
      fill_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= ADDR_ZERO;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_count     = count_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_write = wr_q;
  assign o_mem_data  = wdata_q;

endmodule

// File: doc/sram_block_mover.md
# sram_block_mover

Bus-master engine on the initiator side of the single-port word SRAM. It performs block copy and block fill within the SRAM without processor involvement. It drives the SRAM address, write-enable and write-data pins and samples the SRAM's combinational read data. An external mux selects between this block and other SRAM users while `o_busy` is high.

## Interface
- `ADDR_WIDTH`, default 8: SRAM address width; the SRAM holds 2**ADDR_WIDTH 32-bit words.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_mode`  in  1  0 = copy, 1 = fill.
- `i_src`  in  ADDR_WIDTH  copy source start address (ignored in fill mode).
- `i_dst`  in  ADDR_WIDTH  destination start address.
- `i_len`  in  ADDR_WIDTH+1  word count, 0 to 2**ADDR_WIDTH.
- `i_fill`  in  32  fill pattern (fill mode).
- `o_busy`  out  1  high in READ and WRITE states.
- `o_done`  out  1  one-cycle pulse when the operation ends.
- `o_count`  out  ADDR_WIDTH+1  words written since the last accepted start.
- `o_mem_addr`  out  ADDR_WIDTH  SRAM address.
- `o_mem_write`  out  1  SRAM write enable.
- `o_mem_data`  out  32  SRAM write data.
- `i_mem_data`  in  32  SRAM read data, combinational from `o_mem_addr`.

## Operation
- States: IDLE, READ, WRITE, DONE. Encoding is free.
- **IDLE**
  - `i_start`=1 captures src, dst, len, mode and fill into internal registers, and clears `o_count`.
  - With len=0, the next state is DONE.
  - Otherwise the next state is WRITE if mode=1, or READ if mode=0.
- **READ** (copy mode only)
  - Drive `o_mem_addr`=src_reg and `o_mem_write`=0.
  - At the clock edge, latch `i_mem_data` into data_reg, then go to WRITE.
- **WRITE**
  - Drive `o_mem_addr`=dst_reg and `o_mem_write`=1.
  - `o_mem_data` = data_reg in copy mode, or fill_reg in fill mode.
  - At the clock edge: dst_reg += 1, src_reg += 1 (copy mode only), `o_count` += 1, remaining len -= 1.
  - If remaining len reaches 0, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- **DONE**: `o_done`=1 for exactly one cycle, then go to IDLE.
- **Address arithmetic**: addresses wrap modulo 2**ADDR_WIDTH (e.g. 8'hFF + 1 = 8'h00). `o_count` and len never wrap, because len ≤ 2**ADDR_WIDTH.
- **Overlap**: the copy runs strictly ascending, one word at a time, with no overlap protection.
  - If dst lies in (src, src+len), the source words are overwritten before they are read. The result is a pattern replication, and this is the specified behaviour.
- **Start handling**: `i_start` in READ, WRITE or DONE is ignored; there is no queuing. Input ports other than `i_start` are don't-care outside the IDLE start cycle.
- **Output values outside WRITE**:
  - `o_mem_write`=0 in every state other than WRITE.
  - `o_mem_addr`=0 in IDLE and DONE.
  - `o_mem_data`=0 except in WRITE.

## Timing
- **Reset**
  - `i_rst` asserted at any time, including mid-operation: state=IDLE and all registers = 0.
  - This gives `o_busy`=0, `o_done`=0, `o_count`=0, `o_mem_addr`=0, `o_mem_write`=0, `o_mem_data`=0, immediately and without waiting for a clock edge.
  - A write in flight is abandoned. The SRAM keeps whatever it had committed at earlier edges.
- **Cycle numbering**: the start is accepted at edge E0; "cycle k" is the cycle after edge Ek-1.
  - Copy, len=N≥1: READ and WRITE alternate over cycles 1..2N; DONE is cycle 2N+1; IDLE resumes at cycle 2N+2, when a new start may be accepted.
  - Fill, len=N≥1: WRITE over cycles 1..N; DONE is cycle N+1.
  - len=0: DONE is cycle 1, with no SRAM access and `o_count`=0.
- **Throughput**: copy is 1 word per 2 cycles; fill is 1 word per cycle.
- **SRAM contract**:
  - In copy mode, `i_mem_data` is sampled at the end of the same cycle in which `o_mem_addr` is driven.
  - A write commits at the edge ending a WRITE cycle, so a READ in the following cycle observes it.

## Test plan
- **Copy**: preload mem[0x10..0x13] = 0xA0..0xA3; start copy src=0x10, dst=0x40, len=4.
  - Required: mem[0x40..0x43] = 0xA0..0xA3, `o_done` in cycle 9, `o_count`=4, `o_busy` high in cycles 1–8, and exactly 4 `o_mem_write` cycles.
- **Fill with wrap**: start fill dst=0xFE, len=3, fill=0xDEADBEEF.
  - Required: mem[0xFE], mem[0xFF] and mem[0x00] = 0xDEADBEEF, mem[0x01] unchanged, `o_done` in cycle 4.
- **Zero length**: start with len=0.
  - Required: `o_done` in cycle 1, `o_mem_write` never asserted, `o_count`=0.
- **Overlapping copy**: mem[0x20]=0x11, mem[0x21]=0x22; copy src=0x20, dst=0x21, len=2.
  - Required: mem[0x21]=0x11 and mem[0x22]=0x11.
- **Start while busy**: pulse `i_start` with different args during a len=4 copy, and again during DONE.
  - Required: both pulses are ignored, and only the original copy's writes occur.
- **Reset mid-operation**: assert `i_rst` asynchronously between edges during the third WRITE of a fill with len=8.
  - Required: `o_mem_write`=0 and `o_busy`=0 before the next edge, exactly 2 words written, `o_count`=0.
  - After release, a new fill with len=1 completes normally.
